c3lib_mux2_sel_seq: RTL and testbench

- Select sequencer placed directly upstream of the SVT 2-to-1 mux primitive; drives that mux's select input.
- Takes an asynchronous select request, synchronizes it and qualifies it as stable.
- Changes the mux select only inside a blanking window, with a guard period on each side.
- gate_en tells downstream logic when the mux output is valid.

---
 rtl/c3lib_mux2_sel_seq.sv | 121 ++++++++++++
 tb/tb_c3lib_mux2_sel_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/c3lib_mux2_sel_seq.sv
// Select sequencer for the SVT 2:1 mux: synchronizes and qualifies an async select
// request, then flips the mux select only inside a guarded blanking window.
module c3lib_mux2_sel_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned GUARD_CYC   = 2,
    parameter int unsigned CNT_W       = 4,
    parameter logic        RESET_SEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel_req,
    output logic sel_out,
    output logic gate_en,
    output logic switch_busy,
    output logic switch_done,
    output logic sel_sync
);

    typedef enum logic [3:0] {
        IDLE       = 4'b0001,
        QUAL       = 4'b0010,
        PRE_GUARD  = 4'b0100,
        POST_GUARD = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] GUARD_MAX  = CNT_W'(GUARD_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sel_d, gate_d, done_d;

    // sel_req is sampled by the first stage only; everything else uses sel_sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_SEL}};
        end else begin
            // NOTE: non-blocking so every stage captures the previous stage's old value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], sel_req};
        end
    end

    assign sel_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every variable gets its default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_out;
        gate_d  = gate_en;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_sync != sel_out) begin
                    state_d = QUAL;
                    cnt_d   = CNT_ONE;
                end
            end
            QUAL: begin
                if (sel_sync == sel_out) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_MAX) begin
                    state_d = PRE_GUARD;
                    cnt_d   = CNT_ONE;
                    gate_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRE_GUARD: begin
                if (cnt_q == GUARD_MAX) begin
                    state_d = POST_GUARD;
                    cnt_d   = CNT_ONE;
                    sel_d   = ~sel_out;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            POST_GUARD: begin
                if (cnt_q == GUARD_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    gate_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // Corrupted one-hot encoding: fall back to IDLE with the mux output enabled.
                state_d = IDLE;
                cnt_d   = '0;
                gate_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_out     <= RESET_SEL;
            gate_en     <= 1'b1;
            switch_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_out     <= sel_d;
            gate_en     <= gate_d;
            switch_done <= done_d;
        end
    end

    assign switch_busy = (state_q != IDLE);

endmodule

// File: tb/tb_c3lib_mux2_sel_seq.sv
// Table-driven bench for c3lib_mux2_sel_seq: default instance (a) and a fast
// STABLE_CYC=1/GUARD_CYC=1/SYNC_STAGES=3 instance (b), scoreboard-checked per cycle.
module tb_c3lib_mux2_sel_seq;

    localparam int A_SYNC = 2, A_STAB = 4, A_GUARD = 2;
    localparam int B_SYNC = 3, B_STAB = 1, B_GUARD = 1;
    localparam logic [3:0] RST_EXP = 4'b0100; // {sel, gate, busy, done}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, req_a, sel_out_a, gate_a, busy_a, done_a, sync_a;
    logic rst_n_b, req_b, sel_out_b, gate_b, busy_b, done_b, sync_b;

    c3lib_mux2_sel_seq dut_a (
        .clk(clk), .rst_n(rst_n_a), .sel_req(req_a), .sel_out(sel_out_a),
        .gate_en(gate_a), .switch_busy(busy_a), .switch_done(done_a), .sel_sync(sync_a)
    );

    c3lib_mux2_sel_seq #(
        .SYNC_STAGES(B_SYNC), .STABLE_CYC(B_STAB), .GUARD_CYC(B_GUARD),
        .CNT_W(4), .RESET_SEL(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .sel_req(req_b), .sel_out(sel_out_b),
        .gate_en(gate_b), .switch_busy(busy_b), .switch_done(done_b), .sel_sync(sync_b)
    );

    typedef struct {
        int         dut;
        logic       rst_n;
        logic       req;
        logic       achk;
        logic [4:0] exp;   // {sel, gate, busy, done, sync}
        string      name;
    } vec_t;

    typedef struct {
        int         dut;
        logic [4:0] exp;
        string      name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic [3:0] hist_a = '0;
    logic [3:0] hist_b = '0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: sel/gate/busy/done/sync got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Expected {sel, gate, busy, done} t edges after IDLE first sees the request.
    function automatic logic [3:0] sw_exp(input int t, input logic from, input int s, input int g);
        if (t < 0)         return {from, 1'b1, 1'b0, 1'b0};
        if (t < s)         return {from, 1'b1, 1'b1, 1'b0};
        if (t < s + g)     return {from, 1'b0, 1'b1, 1'b0};
        if (t < s + 2 * g) return {~from, 1'b0, 1'b1, 1'b0};
        if (t == s + 2 * g) return {~from, 1'b1, 1'b0, 1'b1};
        return {~from, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic add(input int dut, input logic rst, input logic req,
                       input logic [3:0] ex, input string name, input logic achk);
        vec_t v;
        logic s;
        if (dut == 0) begin
            hist_a = rst ? {hist_a[2:0], req} : 4'b0000;
            s = hist_a[A_SYNC-1];
        end else begin
            hist_b = rst ? {hist_b[2:0], req} : 4'b0000;
            s = hist_b[B_SYNC-1];
        end
        v.dut = dut; v.rst_n = rst; v.req = req; v.achk = achk;
        v.exp = {ex, s}; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic build();
        // Instance a: reset with request high, then long quiet hold.
        for (int j = 0; j < 3; j++) add(0, 1'b0, 1'b1, RST_EXP, "reset_hold", 1'b0);
        for (int j = 0; j < 50; j++) add(0, 1'b1, 1'b0, 4'b0100, "reset_release_hold", 1'b0);
        // Glitch: request high for 3 cycles only.
        for (int j = 0; j < 13; j++)
            add(0, 1'b1, logic'(j < 3), {1'b0, 1'b1, logic'(j >= 2 && j <= 4), 1'b0}, "glitch_reject", 1'b0);
        for (int j = 0; j < 12; j++)
            add(0, 1'b1, 1'b1, sw_exp(j - A_SYNC, 1'b0, A_STAB, A_GUARD), "clean_switch_0to1", 1'b0);
        for (int j = 0; j < 12; j++)
            add(0, 1'b1, 1'b0, sw_exp(j - A_SYNC, 1'b1, A_STAB, A_GUARD), "clean_switch_1to0", 1'b0);
        // Request withdrawn so sel_sync drops during PRE_GUARD; reverse switch follows.
        for (int j = 0; j < 23; j++)
            add(0, 1'b1, logic'(j < 5),
                (j < 11) ? sw_exp(j - 2, 1'b0, A_STAB, A_GUARD) : sw_exp(j - 11, 1'b1, A_STAB, A_GUARD),
                "reversal_in_guard", 1'b0);
        // Reset lands while in POST_GUARD with sel_out already toggled.
        for (int j = 0; j < 9; j++)
            add(0, 1'b1, 1'b1, sw_exp(j - A_SYNC, 1'b0, A_STAB, A_GUARD), "reset_mid_lead", 1'b0);
        add(0, 1'b0, 1'b1, RST_EXP, "reset_mid_async", 1'b1);
        for (int j = 0; j < 2; j++) add(0, 1'b0, 1'b1, RST_EXP, "reset_mid_hold", 1'b0);
        for (int j = 0; j < 10; j++) add(0, 1'b1, 1'b0, 4'b0100, "reset_mid_after", 1'b0);

        // Instance b: fast parameter set.
        for (int j = 0; j < 3; j++) add(1, 1'b0, 1'b0, RST_EXP, "b_reset", 1'b0);
        for (int j = 0; j < 5; j++) add(1, 1'b1, 1'b0, 4'b0100, "b_idle", 1'b0);
        for (int j = 0; j < 8; j++)
            add(1, 1'b1, 1'b1, sw_exp(j - B_SYNC, 1'b0, B_STAB, B_GUARD), "b_switch_0to1", 1'b0);
        for (int j = 0; j < 3; j++) add(1, 1'b1, 1'b1, 4'b1100, "b_hold1", 1'b0);
        for (int j = 0; j < 8; j++)
            add(1, 1'b1, 1'b0, sw_exp(j - B_SYNC, 1'b1, B_STAB, B_GUARD), "b_switch_1to0", 1'b0);
        for (int j = 0; j < 3; j++) add(1, 1'b1, 1'b0, 4'b0100, "b_hold0", 1'b0);
    endtask

    task automatic compare_pending();
        sb_t e;
        logic [4:0] act;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = (e.dut == 0) ? {sel_out_a, gate_a, busy_a, done_a, sync_a}
                               : {sel_out_b, gate_b, busy_b, done_b, sync_b};
            check(e.name, act, e.exp);
        end
    endtask

    // sel_out may only move while gate_en is low on both sides of the change.
    logic prev_sel_a = 1'b0, prev_gate_a = 1'b1, prev_rst_a = 1'b0;
    logic prev_sel_b = 1'b0, prev_gate_b = 1'b1, prev_rst_b = 1'b0;
    always @(negedge clk) begin
        if (rst_n_a && prev_rst_a && sel_out_a !== prev_sel_a)
            check("a_sel_change_while_gated", {3'b000, prev_gate_a, gate_a}, 5'b00000);
        if (rst_n_b && prev_rst_b && sel_out_b !== prev_sel_b)
            check("b_sel_change_while_gated", {3'b000, prev_gate_b, gate_b}, 5'b00000);
        prev_sel_a <= sel_out_a; prev_gate_a <= gate_a; prev_rst_a <= rst_n_a;
        prev_sel_b <= sel_out_b; prev_gate_b <= gate_b; prev_rst_b <= rst_n_b;
    end

    initial begin
        sb_t e;
        rst_n_a = 1'b0; req_a = 1'b0;
        rst_n_b = 1'b0; req_b = 1'b0;
        build();
        foreach (vecs[i]) begin
            @(negedge clk);
            compare_pending();
            if (vecs[i].dut == 0) begin
                rst_n_a = vecs[i].rst_n; req_a = vecs[i].req;
            end else begin
                rst_n_b = vecs[i].rst_n; req_b = vecs[i].req;
            end
            if (vecs[i].achk) begin
                #1;
                check({vecs[i].name, "_immediate"},
                      {sel_out_a, gate_a, busy_a, done_a, sync_a}, {RST_EXP, 1'b0});
            end
            e.dut = vecs[i].dut; e.exp = vecs[i].exp; e.name = vecs[i].name;
            sb.push_back(e);
        end
        @(negedge clk);
        compare_pending();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
